// File: rtl/hit_judge_scorer.sv
// hit_judge_scorer
//   Sits after the per-lane note shifters. Once per game step it judges the
//   player's key presses against the notes at the strike line. It keeps a
//   saturating combo count, a combo multiplier and a 4-digit BCD score that
//   can drive HEX decoders directly.
//
// Ports
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   tick        in   one-cycle strobe marking the end of a game step
//   note_lanes  in   [LANES] note present at the strike line, per lane
//   key_n       in   [LANES] raw active-low keys, asynchronous to clock
//   score_bcd   out  [15:0] 4 BCD digits, [3:0] = ones ... [15:12] = thousands
//   combo       out  [7:0]  consecutive-hit count, saturates at 255
//   mult        out  [2:0]  current multiplier, 1..MAX_MULT
//   hit_pulse   out  one-cycle pulse when a step is judged HIT
//   miss_pulse  out  one-cycle pulse when a step is judged MISS
//   fsm_state   out  [1:0] current FSM state (0 COLLECT, 1 JUDGE, 2 ADD)
//
// Step protocol: tick closes the current press window. The window is taken
// in COLLECT and judged in the following JUDGE cycle. A HIT then spends
// `mult` ADD cycles incrementing the score by one BCD count per cycle. A tick
// that arrives while JUDGE/ADD is busy is held as a single pending step. That
// step closes on the first COLLECT cycle, and any further ticks are dropped.
module hit_judge_scorer #(
  parameter int LANES      = 4,
  parameter int COMBO_STEP = 4,
  parameter int MAX_MULT   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic [LANES-1:0] note_lanes,
  input  logic [LANES-1:0] key_n,
  output logic [15:0]      score_bcd,
  output logic [7:0]       combo,
  output logic [2:0]       mult,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_JUDGE   = 2'd1,
    ST_ADD     = 2'd2
  } state_t;

  state_t state, state_next;

  // Key synchroniser plus one extra stage for edge detection. All stages
  // reset to 1 so that a released key does not look like a press.
  logic [LANES-1:0] key_s1, key_s2, key_s3;
  logic [LANES-1:0] press;

  logic [LANES-1:0] pressed;
  logic [LANES-1:0] snap_notes;
  logic [LANES-1:0] snap_pressed;
  logic             pending;
  logic [2:0]       add_cnt;

  logic             take;
  logic [LANES-1:0] missed;
  logic [LANES-1:0] wrong;
  logic             step_hit;
  logic             step_miss;
  logic [7:0]       combo_inc;
  int               mult_int;
  logic [2:0]       mult_next;

  assign fsm_state = state;

  // Adds one to a 4-digit BCD value. The caller guards the 9999 case.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- decode
  always_comb begin
    press     = key_s3 & ~key_s2;
    take      = (state == ST_COLLECT) && (tick || pending);
    missed    = snap_notes & ~snap_pressed;
    wrong     = ~snap_notes & snap_pressed;
    step_miss = (missed != '0) || (wrong != '0);
    step_hit  = (snap_notes != '0) && !step_miss;
    combo_inc = (combo == 8'hFF) ? 8'hFF : combo + 8'd1;
    mult_int  = 1 + int'(combo_inc) / COMBO_STEP;
    if (mult_int > MAX_MULT) begin
      mult_int = MAX_MULT;
    end
    mult_next = 3'(mult_int);
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: if (take) state_next = ST_JUDGE;
      ST_JUDGE:   state_next = step_hit ? ST_ADD : ST_COLLECT;
      ST_ADD:     if (add_cnt <= 3'd1) state_next = ST_COLLECT;
      default:    state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------ key inputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= '1;
      key_s2 <= '1;
      key_s3 <= '1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  // ---------------------------------------------- press window and pending
  // A press seen in the tick cycle still belongs to the closing window.
  // Presses seen while busy collect into the next window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pressed      <= '0;
      snap_notes   <= '0;
      snap_pressed <= '0;
      pending      <= 1'b0;
    end else if (take) begin
      snap_notes   <= note_lanes;
      snap_pressed <= pressed | press;
      pressed      <= '0;
      pending      <= 1'b0;
    end else begin
      pressed <= pressed | press;
      if (tick && (state != ST_COLLECT)) begin
        pending <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------- scoring datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd  <= 16'h0000;
      combo      <= 8'd0;
      mult       <= 3'd1;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      add_cnt    <= 3'd0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        ST_JUDGE: begin
          if (step_hit) begin
            combo     <= combo_inc;
            mult      <= mult_next;
            hit_pulse <= 1'b1;
            add_cnt   <= mult_next;
          end else if (step_miss) begin
            combo      <= 8'd0;
            mult       <= 3'd1;
            miss_pulse <= 1'b1;
          end
        end
        ST_ADD: begin
          // The score saturates at 9999, but the ADD cycles still run out.
          if (score_bcd != 16'h9999) begin
            score_bcd <= bcd_inc(score_bcd);
          end
          add_cnt <= add_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_judge_scorer.sv
module tb_hit_judge_scorer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [3:0]  note_lanes;
  logic [3:0]  key_n;
  logic [15:0] score_bcd;
  logic [7:0]  combo;
  logic [2:0]  mult;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [1:0]  fsm_state;

  hit_judge_scorer #(.LANES(4), .COMBO_STEP(4), .MAX_MULT(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tick       (tick),
    .note_lanes (note_lanes),
    .key_n      (key_n),
    .score_bcd  (score_bcd),
    .combo      (combo),
    .mult       (mult),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .fsm_state  (fsm_state)
  );

  // ------------------------------------------------------ clock and reset
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: plain integers, not BCD.
  int m_score = 0;
  int m_combo = 0;
  int m_mult  = 1;
  logic [15:0] exp_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit expired, %0d vectors applied, required completion", n_vec);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Judges one closed window by the game rules and updates the model score.
  task automatic model_judge(input logic [3:0] notes, input logic [3:0] prs,
                             output bit hit, output bit miss);
    hit  = 0;
    miss = 0;
    if (((notes & ~prs) != 4'd0) || ((~notes & prs) != 4'd0)) miss = 1;
    else if (notes != 4'd0) hit = 1;
    if (hit) begin
      m_combo = (m_combo + 1 > 255) ? 255 : m_combo + 1;
      m_mult  = 1 + m_combo / 4;
      if (m_mult > 4) m_mult = 4;
      m_score = (m_score + m_mult > 9999) ? 9999 : m_score + m_mult;
    end
    if (miss) begin
      m_combo = 0;
      m_mult  = 1;
    end
    exp_q.push_back(to_bcd(m_score));
  endtask

  task automatic model_reset();
    m_score = 0;
    m_combo = 0;
    m_mult  = 1;
    exp_q.delete();
  endtask

  // --------------------------------------------------------------- driver
  // One full game step. keys_down is driven low from the start of the step.
  // hold keeps the keys low past the tick. model_pressed is the set of lanes
  // the model treats as pressed in this window.
  task automatic step(input logic [3:0] notes, input logic [3:0] keys_down,
                      input bit hold, input logic [3:0] model_pressed);
    bit h, ms;
    logic [15:0] e;
    note_lanes = notes;
    key_n      = ~keys_down;
    repeat (3) @(negedge clock);
    tick = 1'b1;
    if (!hold) key_n = 4'hF;
    @(negedge clock);
    tick = 1'b0;
    model_judge(notes, model_pressed, h, ms);
    @(negedge clock);
    check("hit_pulse", 32'(hit_pulse), 32'(h));
    check("miss_pulse", 32'(miss_pulse), 32'(ms));
    check("combo", 32'(combo), 32'(m_combo));
    check("mult", 32'(mult), 32'(m_mult));
    if (h) repeat (m_mult) @(negedge clock);
    e = exp_q.pop_front();
    check("score", 32'(score_bcd), 32'(e));
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    bit          h, ms, seen;
    logic [15:0] e;
    logic [3:0]  n, k;
    int          nm;

    reset_n    = 1'b0;
    tick       = 1'b0;
    note_lanes = 4'd0;
    key_n      = 4'hF;
    repeat (3) @(negedge clock);
    check("rst_score", 32'(score_bcd), 32'h0000);
    check("rst_combo", 32'(combo), 32'd0);
    check("rst_mult", 32'(mult), 32'd1);
    check("rst_hit", 32'(hit_pulse), 32'd0);
    check("rst_miss", 32'(miss_pulse), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // A single hit on lane 0.
    step(4'b0001, 4'b0001, 0, 4'b0001);
    check("hit1_score", 32'(score_bcd), 32'h0001);

    // A run of eight hits after a miss: 1+1+1+2+2+2+2+3 on top of 1.
    step(4'b0001, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      n = 4'(1 << (i % 4));
      step(n, n, 0, n);
    end
    check("run8_combo", 32'(combo), 32'd8);
    check("run8_mult", 32'(mult), 32'd3);
    check("run8_score", 32'(score_bcd), 32'h0015);

    // Miss plus wrong key with combo at 5.
    step(4'b0001, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 5; i++) step(4'b0011, 4'b0011, 0, 4'b0011);
    check("pre_wrong_combo", 32'(combo), 32'd5);
    step(4'b0010, 4'b0001, 0, 4'b0001);
    check("wrong_combo", 32'(combo), 32'd0);

    // A key held across three ticks counts only in the first window.
    step(4'b0001, 4'b0001, 1, 4'b0001);
    step(4'b0001, 4'b0001, 1, 4'b0000);
    step(4'b0000, 4'b0001, 1, 4'b0000);
    step(4'b0000, 4'b0000, 0, 4'b0000);

    // A tick during ADD is held and judged after the ADD phase ends.
    for (int i = 0; i < 4; i++) step(4'b0100, 4'b0100, 0, 4'b0100);
    note_lanes = 4'b0001;
    key_n      = 4'b1110;
    repeat (3) @(negedge clock);
    tick  = 1'b1;
    key_n = 4'hF;
    @(negedge clock);
    tick       = 1'b0;
    note_lanes = 4'b0010;
    model_judge(4'b0001, 4'b0001, h, ms);
    @(negedge clock);
    check("pend_first_hit", 32'(hit_pulse), 32'd1);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (miss_pulse) seen = 1;
    end
    check("pend_miss_seen", 32'(seen), 32'd1);
    model_judge(4'b0010, 4'b0000, h, ms);
    e = exp_q.pop_front();
    check("pend_score_a", 32'(score_bcd), 32'(e));
    e = exp_q.pop_front();
    check("pend_score_b", 32'(score_bcd), 32'(e));
    check("pend_combo", 32'(combo), 32'd0);
    check("pend_mult", 32'(mult), 32'd1);

    // An asynchronous reset in the middle of ADD clears everything at once.
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b1000, 0, 4'b1000);
    note_lanes = 4'b1000;
    key_n      = 4'b0111;
    repeat (3) @(negedge clock);
    tick  = 1'b1;
    key_n = 4'hF;
    @(negedge clock);
    tick = 1'b0;
    @(negedge clock);
    check("midadd_hit", 32'(hit_pulse), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_score", 32'(score_bcd), 32'h0000);
    check("arst_combo", 32'(combo), 32'd0);
    check("arst_mult", 32'(mult), 32'd1);
    check("arst_hit", 32'(hit_pulse), 32'd0);
    check("arst_state", 32'(fsm_state), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    @(negedge clock);

    // Random steps, biased toward hits.
    for (int i = 0; i < 60; i++) begin
      n = 4'($urandom_range(0, 15));
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : n;
      step(n, k, 0, k);
    end

    // Drive the score close to the top, then saturate it.
    while (m_score < 9975) begin
      nm = 1 + ((m_combo + 1 > 255) ? 255 : m_combo + 1) / 4;
      if (nm > 4) nm = 4;
      if (m_score + nm <= 9975) step(4'b0001, 4'b0001, 0, 4'b0001);
      else                      step(4'b0001, 4'b0000, 0, 4'b0000);
    end
    step(4'b0001, 4'b0000, 0, 4'b0000);
    for (int i = 0; i < 11; i++) step(4'b0001, 4'b0001, 0, 4'b0001);
    check("sat_pre_score", 32'(score_bcd), 32'h9998);
    step(4'b0001, 4'b0001, 0, 4'b0001);
    check("sat_mult", 32'(mult), 32'd4);
    check("sat_score", 32'(score_bcd), 32'h9999);
    step(4'b0001, 4'b0001, 0, 4'b0001);
    check("sat_hold", 32'(score_bcd), 32'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
